sha256_msg_schedule: RTL

Sequential SHA-256 message-schedule expander. It accepts one 512-bit block as 16 consecutive 32-bit words over a valid/ready input. It then streams W[0..NUM_ROUNDS-1] one word per cycle over a valid/ready output to the round datapath. The sigma0/sigma1 rotate and shift terms are fixed-amount wiring feeding a 32-bit modular adder chain. A 16-entry shift-register window holds the state.

---
 rtl/sha256_msg_schedule.sv | 102 ++++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads 16 words, streams W[0..NUM_ROUNDS-1].
// Ports: clock/reset_n; ctrl_start; data_in_valid/data_in/data_in_ready (load);
//        data_w_valid/data_w/data_w_ready/w_index (schedule out); busy; done.
module sha256_msg_schedule #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ctrl_start,
    input  logic        data_in_valid,
    input  logic [31:0] data_in,
    output logic        data_in_ready,
    output logic        data_w_valid,
    output logic [31:0] data_w,
    input  logic        data_w_ready,
    output logic [5:0]  w_index,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);

    state_t      state;
    state_t      state_n;
    logic [31:0] win [16];
    logic [3:0]  lcnt;
    logic [5:0]  rnd;
    logic        load_fire;
    logic        exp_fire;
    logic [31:0] w_next;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign load_fire = (state == S_LOAD) && data_in_valid;
    assign exp_fire  = (state == S_EXPAND) && data_w_ready;

    // window[k] holds W[t+k]; the new entry is W[t+16]
    assign w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (ctrl_start) state_n = S_LOAD;
            S_LOAD:   if (load_fire && lcnt == 4'd15) state_n = S_EXPAND;
            S_EXPAND: if (exp_fire && rnd == LAST) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
            lcnt <= '0;
            rnd  <= '0;
        end else begin
            if (state == S_IDLE && ctrl_start) begin
                lcnt <= '0;
                rnd  <= '0;
            end
            if (load_fire) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= data_in;
                lcnt    <= lcnt + 4'd1;
            end
            if (exp_fire) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= w_next;
                rnd     <= rnd + 6'd1;
            end
        end
    end

    assign data_in_ready = (state == S_LOAD);
    assign data_w_valid  = (state == S_EXPAND);
    assign data_w        = win[0];
    assign w_index       = rnd;
    assign busy          = (state == S_LOAD) || (state == S_EXPAND);
    assign done          = (state == S_DONE);

endmodule
